// File: rtl/spi_reg_sequencer.sv
// Register-access front end for spi_master: frames one read/write request into the command
// FIFO, then drains one readback word per sent byte and assembles the read data.
module spi_reg_sequencer #(
    parameter int unsigned DATA_BYTES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk_fifo,
    input  logic        reset_fifo,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_rw,
    input  logic [6:0]  iv_req_addr,
    input  logic [31:0] iv_req_wdata,
    output logic        o_done,
    output logic        o_rd_valid,
    output logic [31:0] ov_rd_data,
    output logic        o_frame_err,
    output logic        o_timeout,
    output logic        o_cmd_fifo_wr,
    output logic [8:0]  ov_cmd_fifo_din,
    input  logic        i_cmd_fifo_full,
    output logic        o_rdback_fifo_rd,
    input  logic [8:0]  iv_rdback_fifo_dout,
    input  logic        i_rdback_fifo_empty
);

    localparam logic [2:0]  LastIdx = 3'(DATA_BYTES);
    localparam int unsigned PadBits = 8 * (4 - DATA_BYTES);
    localparam logic [31:0] RdMask  = 32'hFFFF_FFFF >> PadBits;
    localparam logic [15:0] TcntMax = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPush, StDrain, StDone} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_rw;
    logic [6:0]  r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_idx;
    logic [15:0] r_tcnt;
    logic [31:0] r_rd_shift;
    logic [31:0] r_rd_data;
    logic        r_done;
    logic        r_rd_valid;
    logic        r_frame_err;
    logic        r_timeout;

    logic        w_req_ready;
    logic        w_cmd_wr;
    logic        w_rd_pop;
    logic        w_is_last;
    logic        w_clean_end;
    logic        w_frame_bad;
    logic        w_tmo;
    logic [7:0]  w_cmd_byte;
    logic [31:0] w_rd_next;

    assign w_is_last  = (r_idx == LastIdx);
    // Write data is pre-aligned so the next data byte is always in the top lane.
    assign w_cmd_byte = (r_idx == 3'd0) ? {r_rw, r_addr} : r_wdata[31:24];
    assign w_rd_next  = {r_rd_shift[23:0], iv_rdback_fifo_dout[7:0]};

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_cmd_wr     = 1'b0;
        w_rd_pop     = 1'b0;
        w_clean_end  = 1'b0;
        w_frame_bad  = 1'b0;
        w_tmo        = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_req_ready = 1'b1;
                if (i_req_valid) w_state_next = StPush;
            end
            StPush: begin
                w_cmd_wr = !i_cmd_fifo_full;
                if (w_cmd_wr && w_is_last) w_state_next = StDrain;
            end
            StDrain: begin
                w_rd_pop = !i_rdback_fifo_empty;
                if (w_rd_pop) begin
                    if (iv_rdback_fifo_dout[8] != w_is_last) begin
                        w_frame_bad  = 1'b1;
                        w_state_next = StDone;
                    end else if (w_is_last) begin
                        w_clean_end  = 1'b1;
                        w_state_next = StDone;
                    end
                end else if (r_tcnt == TcntMax) begin
                    w_tmo        = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_fifo) begin
        if (!reset_fifo) r_state <= StIdle;
        else             r_state <= w_state_next;
    end

    always_ff @(posedge clk_fifo) begin
        if (!reset_fifo) begin
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_idx       <= '0;
            r_tcnt      <= '0;
            r_rd_shift  <= '0;
            r_rd_data   <= '0;
            r_done      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done      <= w_clean_end;
            r_rd_valid  <= w_clean_end & r_rw;
            r_frame_err <= w_frame_bad;
            r_timeout   <= w_tmo;
            if (w_clean_end && r_rw) r_rd_data <= w_rd_next & RdMask;

            if (w_req_ready && i_req_valid) begin
                r_rw       <= i_req_rw;
                r_addr     <= iv_req_addr;
                r_wdata    <= i_req_rw ? 32'd0 : (iv_req_wdata << PadBits);
                r_idx      <= '0;
                r_rd_shift <= '0;
            end

            if (w_cmd_wr) begin
                if (w_is_last) begin
                    r_idx  <= '0;
                    r_tcnt <= '0;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
                if (r_idx != 3'd0) r_wdata <= r_wdata << 8;
            end

            if (r_state == StDrain) begin
                if (w_rd_pop) begin
                    r_tcnt <= '0;
                    r_idx  <= r_idx + 3'd1;
                    // Byte 0 echoes the header; only data-phase MISO bytes are kept.
                    if (r_rw && r_idx != 3'd0) r_rd_shift <= w_rd_next;
                end else begin
                    r_tcnt <= r_tcnt + 16'd1;
                end
            end
        end
    end

    // While in reset every output is forced low, including the combinational strobes.
    assign o_req_ready      = w_req_ready & reset_fifo;
    assign o_cmd_fifo_wr    = w_cmd_wr & reset_fifo;
    assign ov_cmd_fifo_din  = reset_fifo ? {w_is_last, w_cmd_byte} : 9'd0;
    assign o_rdback_fifo_rd = w_rd_pop & reset_fifo;
    assign o_done           = r_done & reset_fifo;
    assign o_rd_valid       = r_rd_valid & reset_fifo;
    assign o_frame_err      = r_frame_err & reset_fifo;
    assign o_timeout        = r_timeout & reset_fifo;
    assign ov_rd_data       = reset_fifo ? r_rd_data : 32'd0;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Scoreboard bench for spi_reg_sequencer: models the two spi_master FIFOs and an SPI
// responder, predicts command words and completion events from the framing rules.
module tb_spi_reg_sequencer;

    localparam int unsigned DB     = 2;
    localparam int unsigned TMO    = 16;
    localparam int          NB     = DB + 1;
    localparam logic [31:0] RdMask = 32'h0000_FFFF;

    logic        clk_fifo = 1'b0;
    logic        reset_fifo = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_rw = 1'b0;
    logic [6:0]  iv_req_addr = '0;
    logic [31:0] iv_req_wdata = '0;
    logic        o_done;
    logic        o_rd_valid;
    logic [31:0] ov_rd_data;
    logic        o_frame_err;
    logic        o_timeout;
    logic        o_cmd_fifo_wr;
    logic [8:0]  ov_cmd_fifo_din;
    logic        i_cmd_fifo_full;
    logic        o_rdback_fifo_rd;
    logic [8:0]  iv_rdback_fifo_dout;
    logic        i_rdback_fifo_empty;

    always #5 clk_fifo = ~clk_fifo;

    spi_reg_sequencer #(
        .DATA_BYTES     (DB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_fifo            (clk_fifo),
        .reset_fifo          (reset_fifo),
        .i_req_valid         (i_req_valid),
        .o_req_ready         (o_req_ready),
        .i_req_rw            (i_req_rw),
        .iv_req_addr         (iv_req_addr),
        .iv_req_wdata        (iv_req_wdata),
        .o_done              (o_done),
        .o_rd_valid          (o_rd_valid),
        .ov_rd_data          (ov_rd_data),
        .o_frame_err         (o_frame_err),
        .o_timeout           (o_timeout),
        .o_cmd_fifo_wr       (o_cmd_fifo_wr),
        .ov_cmd_fifo_din     (ov_cmd_fifo_din),
        .i_cmd_fifo_full     (i_cmd_fifo_full),
        .o_rdback_fifo_rd    (o_rdback_fifo_rd),
        .iv_rdback_fifo_dout (iv_rdback_fifo_dout),
        .i_rdback_fifo_empty (i_rdback_fifo_empty)
    );

    typedef struct {
        int          kind;  // 0 done, 1 frame error, 2 timeout
        logic        rd_valid;
        logic [31:0] rd_data;
    } evt_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          evt_cyc = -1;
    int          last_cmd_cyc = -1;
    int          rel_credit = 0;
    bit          force_full = 1'b0;
    bit          full_mode = 1'b0;
    logic [31:0] model_rd = '0;
    logic [8:0]  exp_cmd[$];
    evt_t        exp_evt[$];
    logic [8:0]  spi_q[$];
    logic [8:0]  rb_q[$];

    always @(posedge clk_fifo) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
    endtask

    // Command FIFO back-pressure: directed stalls plus optional random fullness.
    initial begin
        i_cmd_fifo_full = 1'b0;
        forever begin
            @(posedge clk_fifo);
            #2;
            i_cmd_fifo_full = force_full | (full_mode && ($urandom_range(0, 3) == 0));
        end
    end

    // SPI responder + FWFT readback FIFO: one word released per byte already sent.
    initial begin
        logic pop;
        i_rdback_fifo_empty = 1'b1;
        iv_rdback_fifo_dout = '0;
        forever begin
            @(negedge clk_fifo);
            pop = o_rdback_fifo_rd;
            @(posedge clk_fifo);
            #2;
            if (pop && rb_q.size() > 0) void'(rb_q.pop_front());
            if (spi_q.size() > 0 && rel_credit > 0 && $urandom_range(0, 3) != 0) begin
                rb_q.push_back(spi_q.pop_front());
                rel_credit--;
            end
            i_rdback_fifo_empty = (rb_q.size() == 0);
            iv_rdback_fifo_dout = (rb_q.size() == 0) ? 9'($urandom) : rb_q[0];
        end
    end

    // Monitor: compares command writes and completion pulses against the queues.
    initial begin
        evt_t e;
        forever begin
            @(negedge clk_fifo);
            if (reset_fifo) begin
                if (i_cmd_fifo_full) chk("no_write_while_full", 32'(o_cmd_fifo_wr), 32'd0);
                if (o_cmd_fifo_wr) begin
                    rel_credit++;
                    if (ov_cmd_fifo_din[8]) last_cmd_cyc = cyc;
                    if (exp_cmd.size() == 0) fail_now("cmd_unexpected");
                    else chk("cmd_word", 32'(ov_cmd_fifo_din), 32'(exp_cmd.pop_front()));
                end
                if (o_done || o_rd_valid || o_frame_err || o_timeout) begin
                    evt_cyc = cyc;
                    if (exp_evt.size() == 0) begin
                        fail_now("evt_unexpected");
                    end else begin
                        e = exp_evt.pop_front();
                        chk("evt_done", 32'(o_done), 32'(e.kind == 0));
                        chk("evt_frame_err", 32'(o_frame_err), 32'(e.kind == 1));
                        chk("evt_timeout", 32'(o_timeout), 32'(e.kind == 2));
                        chk("evt_rd_valid", 32'(o_rd_valid), 32'(e.rd_valid));
                        chk("evt_rd_data", ov_rd_data, e.rd_data);
                    end
                end
            end
        end
    end

    // Reference frame: header {rw,addr}, then data MSB first (or zeros for a read).
    task automatic push_frame(input logic rw, input logic [6:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < NB; i++) begin
            logic [7:0] b;
            if (i == 0) b = {rw, addr};
            else if (rw) b = 8'h00;
            else b = 8'((wdata >> (8 * (NB - 1 - i))) & 32'hFF);
            exp_cmd.push_back({(i == NB - 1), b});
        end
    endtask

    // Readback words with correct markers; data bytes taken MSB first from 'data'.
    task automatic push_resp(input logic [31:0] data);
        for (int i = 0; i < NB; i++) begin
            logic [7:0] m;
            m = (i == 0) ? 8'($urandom) : 8'((data >> (8 * (NB - 1 - i))) & 32'hFF);
            spi_q.push_back({(i == NB - 1), m});
        end
    endtask

    task automatic push_evt(input int kind, input logic rdv);
        evt_t e;
        e.kind     = kind;
        e.rd_valid = rdv;
        e.rd_data  = model_rd;
        exp_evt.push_back(e);
    endtask

    task automatic txn_start(input logic rw, input logic [6:0] addr, input logic [31:0] wdata,
                             output int acc_cyc);
        i_req_valid  = 1'b1;
        i_req_rw     = rw;
        iv_req_addr  = addr;
        iv_req_wdata = wdata;
        acc_cyc      = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_fifo);
            if (o_req_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        @(posedge clk_fifo);
        #1;
        i_req_valid  = 1'b0;
        i_req_rw     = 1'($urandom);
        iv_req_addr  = 7'($urandom);
        iv_req_wdata = $urandom;
        if (acc_cyc < 0) fail_now("req_accept");
    endtask

    task automatic txn_wait(input string name);
        int c;
        c = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_fifo);
            if (o_req_ready) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) fail_now(name);
        else chk(name, 32'(c), 32'(evt_cyc + 1));
        @(posedge clk_fifo);
        #1;
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [31:0] wdata, output int acc);
        push_frame(1'b0, addr, wdata);
        push_resp($urandom);
        push_evt(0, 1'b0);
        txn_start(1'b0, addr, wdata, acc);
        txn_wait("write_ready_return");
    endtask

    task automatic do_read(input logic [6:0] addr, input logic [31:0] data, output int acc);
        push_frame(1'b1, addr, 32'd0);
        push_resp(data);
        model_rd = data & RdMask;
        push_evt(0, 1'b1);
        txn_start(1'b1, addr, $urandom, acc);
        txn_wait("read_ready_return");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic rw;

        repeat (3) @(posedge clk_fifo);
        @(negedge clk_fifo);
        chk("reset_strobes", 32'({o_req_ready, o_done, o_rd_valid, o_frame_err, o_timeout,
                                  o_cmd_fifo_wr, o_rdback_fifo_rd}), 32'd0);
        chk("reset_rd_data", ov_rd_data, 32'd0);
        chk("reset_cmd_din", 32'(ov_cmd_fifo_din), 32'd0);
        @(posedge clk_fifo);
        #1;
        reset_fifo = 1'b1;
        @(negedge clk_fifo);
        chk("post_reset_ready", 32'(o_req_ready), 32'd1);
        @(posedge clk_fifo);
        #1;

        // Directed write: three back-to-back command words.
        do_write(7'h15, 32'h0000_A55A, acc);
        chk("write_last_cmd_cycle", 32'(last_cmd_cyc), 32'(acc + 3));

        // Directed read returning 12,34.
        do_read(7'h03, 32'h0000_1234, acc);
        chk("read_data_held", ov_rd_data, 32'h0000_1234);

        // Five-cycle stall after the first command write.
        push_frame(1'b0, 7'h2A, 32'h0000_C3E1);
        push_resp($urandom);
        push_evt(0, 1'b0);
        txn_start(1'b0, 7'h2A, 32'h0000_C3E1, acc);
        @(posedge clk_fifo);
        #1;
        force_full = 1'b1;
        repeat (5) @(posedge clk_fifo);
        #1;
        force_full = 1'b0;
        txn_wait("stall_ready_return");
        chk("stall_last_cmd_cycle", 32'(last_cmd_cyc), 32'(acc + 8));

        // Readback word 1 carries a premature last marker.
        push_frame(1'b1, 7'h44, 32'd0);
        spi_q.push_back({1'b0, 8'($urandom)});
        spi_q.push_back({1'b1, 8'($urandom)});
        push_evt(1, 1'b0);
        txn_start(1'b1, 7'h44, 32'd0, acc);
        txn_wait("frame_err_ready_return");
        rel_credit = 0;

        // Readback FIFO stays empty: timeout 16 cycles after DRAIN entry.
        push_frame(1'b1, 7'h7F, 32'd0);
        push_evt(2, 1'b0);
        txn_start(1'b1, 7'h7F, 32'd0, acc);
        txn_wait("timeout_ready_return");
        chk("timeout_latency", 32'(evt_cyc), 32'(last_cmd_cyc + 1 + int'(TMO)));
        chk("timeout_rd_data_kept", ov_rd_data, model_rd);
        rel_credit = 0;

        // One-cycle reset in the middle of DRAIN.
        push_frame(1'b0, 7'h11, 32'h0000_BEEF);
        txn_start(1'b0, 7'h11, 32'h0000_BEEF, acc);
        for (int k = 0; k < 50 && exp_cmd.size() != 0; k++) @(negedge clk_fifo);
        if (exp_cmd.size() != 0) fail_now("reset_test_push");
        @(posedge clk_fifo);
        #1;
        reset_fifo = 1'b0;
        rb_q.delete();
        spi_q.delete();
        rel_credit = 0;
        exp_cmd.delete();
        @(negedge clk_fifo);
        chk("midreset_strobes", 32'({o_req_ready, o_done, o_rd_valid, o_frame_err, o_timeout,
                                     o_cmd_fifo_wr, o_rdback_fifo_rd}), 32'd0);
        chk("midreset_rd_data", ov_rd_data, 32'd0);
        chk("midreset_cmd_din", 32'(ov_cmd_fifo_din), 32'd0);
        @(posedge clk_fifo);
        #1;
        reset_fifo = 1'b1;
        model_rd   = '0;
        @(negedge clk_fifo);
        chk("after_reset_ready", 32'(o_req_ready), 32'd1);
        chk("after_reset_done", 32'(o_done), 32'd0);
        @(posedge clk_fifo);
        #1;
        do_write(7'h5C, 32'h0000_0F0F, acc);

        // Randomized traffic with random command FIFO back-pressure.
        full_mode = 1'b1;
        for (int t = 0; t < 40; t++) begin
            rw = 1'($urandom);
            if (rw) do_read(7'($urandom), $urandom, acc);
            else    do_write(7'($urandom), $urandom, acc);
        end
        full_mode = 1'b0;
        repeat (4) @(posedge clk_fifo);

        chk("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
        chk("evt_queue_drained", 32'(exp_evt.size()), 32'd0);
        chk("final_rd_data", ov_rd_data, model_rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_sequencer.md
# spi_reg_sequencer

Register-access front end for `spi_master`. It converts one register read or write request into a framed byte stream on the `spi_master` command FIFO. It then drains exactly one readback word per transmitted byte from the readback FIFO and assembles read data. It sits directly upstream of `spi_master`, on the `clk_fifo` side, between the system register bus and the two SPI FIFOs.

## Interface
- `DATA_BYTES`, default 2: data bytes per frame; legal values 1..4.
- `TIMEOUT_CYCLES`, default 65535: maximum idle `clk_fifo` cycles in DRAIN before abort; 16-bit counter.
- `clk_fifo` input, 1: single clock for all logic.
- `reset_fifo` input, 1: synchronous, active-low reset.
- `i_req_valid` input, 1: request strobe.
- `o_req_ready` output, 1: request accepted when `i_req_valid & o_req_ready`.
- `i_req_rw` input, 1: 1 = read, 0 = write.
- `iv_req_addr` input, 7: register address.
- `iv_req_wdata` input, 32: write data; low `8*DATA_BYTES` bits used.
- `o_done` output, 1: one-cycle pulse when a transaction completes cleanly.
- `o_rd_valid` output, 1: one-cycle pulse coincident with `o_done` for reads.
- `ov_rd_data` output, 32: assembled read data, zero-extended, held until the next read completes.
- `o_frame_err` output, 1: one-cycle pulse on a frame-marker mismatch.
- `o_timeout` output, 1: one-cycle pulse on a DRAIN timeout.
- `o_cmd_fifo_wr` output, 1: command FIFO write.
- `ov_cmd_fifo_din` output, 9: bit 8 = last byte of frame (CS release); bits 7:0 = byte.
- `i_cmd_fifo_full` input, 1: command FIFO full.
- `o_rdback_fifo_rd` output, 1: readback FIFO pop.
- `iv_rdback_fifo_dout` input, 9: first-word-fall-through data; bit 8 = last-byte flag; bits 7:0 = MISO byte.
- `i_rdback_fifo_empty` input, 1: readback FIFO empty.

## Operation
- Frame is `N = DATA_BYTES + 1` bytes:
  - byte 0 = `{rw, addr[6:0]}`;
  - bytes 1..DATA_BYTES = data MSB first for a write, or 8'h00 dummy for a read;
  - bit 8 = 1 only on byte `N-1`.
- The state machine has four states, with index counter `idx` (3 bits) and timeout counter `tcnt` (16 bits).
- IDLE:
  - `o_req_ready = 1`.
  - On accept, latch rw, addr and wdata; set `idx = 0`; go to PUSH.
- PUSH:
  - `o_cmd_fifo_wr = !i_cmd_fifo_full` (combinational); `ov_cmd_fifo_din` = byte `idx`.
  - Each write increments `idx`.
  - After the write of byte `N-1`: set `idx = 0`, `tcnt = 0`, go to DRAIN.
- DRAIN:
  - `o_rdback_fifo_rd = !i_rdback_fifo_empty` (combinational).
  - Each pop checks `dout[8] == (idx == N-1)`; on mismatch pulse `o_frame_err` next cycle and go to IDLE with no `o_done`.
  - Byte 0 echo is discarded. For reads, bytes 1..N-1 shift into `rd_shift` (`rd_shift = {rd_shift[23:0], dout[7:0]}`). For writes, data echoes are discarded.
  - Each pop clears `tcnt`; otherwise `tcnt` increments.
  - `tcnt == TIMEOUT_CYCLES-1` with no pop: pulse `o_timeout` and go to IDLE.
  - Pop of byte `N-1` with a correct marker: go to DONE.
- DONE (one cycle):
  - `o_done = 1`.
  - For reads: `o_rd_valid = 1` and `ov_rd_data = rd_shift` masked to `8*DATA_BYTES` bits.
  - Go to IDLE.
- New requests are not accepted in PUSH, DRAIN or DONE.
- While `reset_fifo = 0`, all outputs are 0, including `o_req_ready`, and `ov_rd_data = 0`. State returns to IDLE and counters clear.
- Reset mid-transaction abandons the frame without flushing the FIFOs. The system resets `spi_master` together with this block; any stale readback word otherwise produces `o_frame_err`.

## Timing
- Request accepted at cycle 0. With the command FIFO never full, bytes are written at cycles 1..N, one per cycle, and DRAIN starts at cycle N+1.
- `i_cmd_fifo_full` high stalls PUSH with no write that cycle. The byte and `idx` hold; there is no data loss.
- Pops happen in the same cycle `i_rdback_fifo_empty` is low (FWFT). Back-to-back pops are allowed.
- Last pop at cycle T: `o_done`/`o_rd_valid` at T+1; `o_req_ready` at T+2.
- `o_frame_err` and `o_timeout` pulse the cycle after detection; `o_req_ready` follows one cycle later.
- Outputs `o_done`, `o_rd_valid`, `o_frame_err`, `o_timeout` and `ov_rd_data` are registered. FIFO strobes are combinational from state plus flag.
- Minimum transaction for `DATA_BYTES = 2` with an instant SPI: 1 + 3 + 3 + 1 cycles.

## Test plan
- Write, `DATA_BYTES=2`, addr 7'h15, wdata 16'hA55A:
  - cmd FIFO receives 9'h015, 9'h0A5, 9'h15A on consecutive cycles;
  - after three readback words (last with bit 8 set), `o_done` pulses and `o_rd_valid` stays 0.
- Read, addr 7'h03, returned MISO bytes xx, 8'h12, 8'h34:
  - cmd words 9'h083, 9'h000, 9'h100;
  - `ov_rd_data = 32'h0000_1234` with `o_rd_valid` and `o_done` pulsing together.
- Hold `i_cmd_fifo_full` high for 5 cycles after the first write:
  - no write and no `idx` change during the stall;
  - remaining bytes are written in order after release.
- Readback word 1 arrives with bit 8 = 1:
  - `o_frame_err` pulses once, with no `o_done`;
  - `o_req_ready` returns high two cycles later.
- `TIMEOUT_CYCLES=16`, readback FIFO held empty after PUSH:
  - `o_timeout` pulses exactly 16 cycles after DRAIN entry;
  - `ov_rd_data` is unchanged.
- Drive `reset_fifo` low for one cycle mid-DRAIN:
  - next cycle all outputs are 0;
  - after release `o_req_ready = 1` and a new write completes normally.
